// File: rtl/seg_pkg.sv
// Shared constants for the six-digit voltage display: segment codes, the
// clamp limit and the binary-to-BCD converter state encoding.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [19:0] DATA_MAX = 20'd99_999;

    function automatic logic [7:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_volt_disp_bin2bcd.sv
// Sequential 20-bit binary to 5-digit BCD converter (shift-add-3, one bit per cycle).
// state    | meaning
// ST_IDLE  | waiting for start; bcd holds the last result
// ST_SHIFT | 20 shift-add-3 steps, one per cycle
// ST_DONE  | one-cycle result-valid strobe
module bin2bcd
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [19:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    conv_state_t state;
    logic [39:0] sr;
    logic [39:0] sr_adj;
    logic [4:0]  shift_cnt;

    // upper half is the BCD accumulator, lower half the binary still to shift in
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 5; i++) begin
            if (sr[20 + 4*i +: 4] >= 4'd5)
                sr_adj[20 + 4*i +: 4] = sr[20 + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sr        <= '0;
            shift_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sr        <= {20'd0, bin};
                        shift_cnt <= 5'd19;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sr <= {sr_adj[38:0], 1'b0};
                    if (shift_cnt == 5'd0)
                        state <= ST_DONE;
                    else
                        shift_cnt <= shift_cnt - 5'd1;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign bcd  = sr[39:20];

endmodule

// File: rtl/seg_volt_disp.sv
// Six-digit multiplexed voltage display: periodic capture, BCD conversion, scan and decode.
// Define SEG_LZB_EN to blank leading zeros above the decimal-point digit.
module seg_volt_disp
    import seg_pkg::*;
#(
    parameter int CNT_SCAN_MAX = 49_999,
    parameter int CNT_REF_MAX  = 4_999_999,
    parameter int DOT_POS      = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] data,
    input  logic        sign,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    localparam int REF_W  = (CNT_REF_MAX  > 0) ? $clog2(CNT_REF_MAX + 1)  : 1;
    localparam int SCAN_W = (CNT_SCAN_MAX > 0) ? $clog2(CNT_SCAN_MAX + 1) : 1;

    logic [REF_W-1:0]  cnt_ref;
    logic [SCAN_W-1:0] cnt_scan;
    logic [2:0]        digit_idx;
    logic              tick;
    logic              start_q;
    logic [19:0]       cap_bin;
    logic              cap_sign;
    logic              busy;
    logic              done;
    logic [19:0]       conv_bcd;
    logic [19:0]       disp_bcd;
    logic              disp_sign;
    logic [4:0]        blank;
    logic [3:0]        digit;
    logic              blk;
    logic [5:0]        sel_next;
    logic [7:0]        seg_next;

    assign tick = (cnt_ref == REF_W'(CNT_REF_MAX));

    // start_q also counts as busy: the converter only sees it one cycle later
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_ref  <= '0;
            start_q  <= 1'b0;
            cap_bin  <= '0;
            cap_sign <= 1'b0;
        end else begin
            cnt_ref <= tick ? '0 : cnt_ref + REF_W'(1);
            start_q <= 1'b0;
            if (tick && !busy && !start_q) begin
                cap_bin  <= (data > DATA_MAX) ? DATA_MAX : data;
                cap_sign <= sign;
                start_q  <= 1'b1;
            end
        end
    end

    bin2bcd u_bin2bcd (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .start (start_q),
        .bin   (cap_bin),
        .busy  (busy),
        .done  (done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            disp_bcd  <= '0;
            disp_sign <= 1'b0;
        end else if (done) begin
            disp_bcd  <= conv_bcd;
            disp_sign <= cap_sign;
        end
    end

`ifdef SEG_LZB_EN
    logic lead;
    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            lead = lead & (disp_bcd[4*i +: 4] == 4'd0);
            if (i > DOT_POS)
                blank[i] = lead;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        digit = 4'd0;
        blk   = 1'b0;
        case (digit_idx)
            3'd0: begin digit = disp_bcd[3:0];   blk = blank[0]; end
            3'd1: begin digit = disp_bcd[7:4];   blk = blank[1]; end
            3'd2: begin digit = disp_bcd[11:8];  blk = blank[2]; end
            3'd3: begin digit = disp_bcd[15:12]; blk = blank[3]; end
            3'd4: begin digit = disp_bcd[19:16]; blk = blank[4]; end
            default: ;
        endcase
        seg_next = SEG_BLANK;
        if (digit_idx == 3'd5)
            seg_next = disp_sign ? SEG_MINUS : SEG_BLANK;
        else if (digit_idx < 3'd5)
            seg_next = blk ? SEG_BLANK : seg_code(digit);
        if (digit_idx == 3'(DOT_POS))
            seg_next[7] = 1'b0;
        sel_next = ~(6'b000001 << digit_idx);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_scan  <= '0;
            digit_idx <= 3'd0;
            sel       <= 6'b111111;
            seg       <= SEG_BLANK;
        end else begin
            if (cnt_scan == SCAN_W'(CNT_SCAN_MAX)) begin
                cnt_scan  <= '0;
                digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                cnt_scan <= cnt_scan + SCAN_W'(1);
            end
            sel <= sel_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_volt_disp.sv
// Self-checking bench for seg_volt_disp: directed scenarios plus random values
// against an arithmetic model of the displayed number.
module tb_seg_volt_disp;

    localparam int SCAN_MAX = 3;
    localparam int REF_MAX  = 99;
    localparam int DOT      = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] data  = '0;
    logic        sign  = 1'b0;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    int exp_val = 0;
    bit exp_sign = 1'b0;

    seg_volt_disp #(
        .CNT_SCAN_MAX (SCAN_MAX),
        .CNT_REF_MAX  (REF_MAX),
        .DOT_POS      (DOT)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .data      (data),
        .sign      (sign),
        .sel       (sel),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    // edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [7:0] model_seg(input int idx, input int val, input bit sg);
        logic [7:0] codes [10];
        logic [7:0] s;
        codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        if (idx == 5) return sg ? 8'hBF : 8'hFF;
        s = codes[(val / pow10(idx)) % 10];
`ifdef SEG_LZB_EN
        if (idx > DOT && val < pow10(idx)) s = 8'hFF;
`endif
        if (idx == DOT) s[7] = 1'b0;
        return s;
    endfunction

    function automatic logic [20:0] model_disp(input int val, input bit sg);
        logic [20:0] r;
        r[20] = sg;
        for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((val / pow10(i)) % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_disp(input string tag);
        check(tag, {11'd0, dut.disp_sign, dut.disp_bcd}, {11'd0, model_disp(exp_val, exp_sign)});
    endtask

    task automatic check_frame(input int start);
        int idx;
        logic [5:0] e_sel;
        for (int j = 0; j < 24; j++) begin
            wait_cyc(start + j);
            idx   = ((cyc - 1) / 4) % 6;
            e_sel = ~(6'b000001 << idx);
            check("sel", {26'd0, sel}, {26'd0, e_sel});
            check("seg", {24'd0, seg}, {24'd0, model_seg(idx, exp_val, exp_sign)});
        end
    endtask

    task automatic conv(input int k, input int raw, input bit sg);
        wait_cyc(100*k - 2);
        data = 20'(raw);
        sign = sg;
        wait_cyc(100*k + 21);
        check_disp("hold_before_update");
        wait_cyc(100*k + 22);
        exp_val  = (raw > 99999) ? 99999 : raw;
        exp_sign = sg;
        check_disp("update_at_22");
        check_frame(100*k + 24);
    endtask

    initial begin
        int raw;
        bit sg;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sel", {26'd0, sel}, 32'h3F);
        check("rst_seg", {24'd0, seg}, 32'hFF);
        check_disp("rst_disp");
        rst_n = 1'b1;

        conv(1, 1234, 1'b0);
        conv(2, 4999, 1'b1);
        conv(3, 20'hFFFFF, 1'b0);
        conv(4, 7, 1'b0);

        // input change during a conversion must not leak into it
        wait_cyc(498);
        data = 20'd1234;
        sign = 1'b0;
        wait_cyc(505);
        data = 20'd4321;
        wait_cyc(522);
        exp_val  = 1234;
        exp_sign = 1'b0;
        check_disp("capture_isolated");
        check_frame(524);
        conv(6, 4321, 1'b0);

        for (int k = 7; k < 15; k++) begin
            case ($urandom_range(0, 2))
                0:       raw = int'($urandom_range(100000, 20'hFFFFF));
                1:       raw = int'($urandom_range(0, 99));
                default: raw = int'($urandom_range(0, 99999));
            endcase
            sg = 1'($urandom_range(0, 1));
            conv(k, raw, sg);
        end

        // reset in the middle of a conversion
        wait_cyc(1498);
        data = 20'd31415;
        sign = 1'b1;
        wait_cyc(1510);
        rst_n = 1'b0;
        #1;
        exp_val  = 0;
        exp_sign = 1'b0;
        check("midrst_sel", {26'd0, sel}, 32'h3F);
        check("midrst_seg", {24'd0, seg}, 32'hFF);
        check_disp("midrst_disp");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(50);
        check_disp("post_rst_disp");
        check_frame(24);
        wait_cyc(121);
        check_disp("post_rst_hold");
        wait_cyc(122);
        exp_val  = 31415;
        exp_sign = 1'b1;
        check_disp("post_rst_update");
        check_frame(124);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
